// File: rtl/csa_sbox_capture_if.sv
// Round-level bus between the CSA sbox layer / controller and the capture stage.
// The master drives session control and sbox outputs; the slave returns registered state.
interface csa_sbox_capture_if;
    logic        start;
    logic        adv;
    logic [1:0]  s1;
    logic [1:0]  s2;
    logic [1:0]  s3;
    logic [1:0]  s4;
    logic [1:0]  s5;
    logic [1:0]  s6;
    logic [1:0]  s7;
    logic [3:0]  x;
    logic [3:0]  y;
    logic [3:0]  z;
    logic        p;
    logic        q;
    logic        gen_mode;
    logic        busy;
    logic [7:0]  round;
    logic [15:0] byte_cnt;
    logic        init_done;
    logic        byte_tick;

    modport master (
        output start, adv, s1, s2, s3, s4, s5, s6, s7,
        input  x, y, z, p, q, gen_mode, busy, round, byte_cnt, init_done, byte_tick
    );

    modport slave (
        input  start, adv, s1, s2, s3, s4, s5, s6, s7,
        output x, y, z, p, q, gen_mode, busy, round, byte_cnt, init_done, byte_tick
    );
endinterface

// File: rtl/csa_sbox_capture.sv
// CSA round-state capture: registers sbox outputs into X/Y/Z/p/q and sequences
// the IDLE -> INIT -> GEN phases with per-byte round and byte counting.
module csa_sbox_capture #(
    parameter int INIT_ROUNDS     = 32,
    parameter int ROUNDS_PER_BYTE = 4
) (
    input  logic               clk,
    input  logic               rst,
    csa_sbox_capture_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_GEN} state_t;

    localparam logic [7:0] INIT_LAST = 8'(INIT_ROUNDS - 1);
    localparam logic [7:0] BYTE_LAST = 8'(ROUNDS_PER_BYTE - 1);

    state_t      state_reg, state_next;
    logic [3:0]  x_reg, x_next;
    logic [3:0]  y_reg, y_next;
    logic [3:0]  z_reg, z_next;
    logic        p_reg, p_next;
    logic        q_reg, q_next;
    logic [7:0]  round_reg, round_next;
    logic [15:0] byte_cnt_reg, byte_cnt_next;
    logic        init_done_reg, init_done_next;
    logic        byte_tick_reg, byte_tick_next;

    always_comb begin
        state_next     = state_reg;
        x_next         = x_reg;
        y_next         = y_reg;
        z_next         = z_reg;
        p_next         = p_reg;
        q_next         = q_reg;
        round_next     = round_reg;
        byte_cnt_next  = byte_cnt_reg;
        init_done_next = 1'b0;
        byte_tick_next = 1'b0;

        if (bus.start) begin
            // A new session always wins over a same-cycle adv.
            state_next    = ST_INIT;
            x_next        = 4'd0;
            y_next        = 4'd0;
            z_next        = 4'd0;
            p_next        = 1'b0;
            q_next        = 1'b0;
            round_next    = 8'd0;
            byte_cnt_next = 16'd0;
        end else if (bus.adv && state_reg != ST_IDLE) begin
            x_next = {bus.s4[0], bus.s3[0], bus.s2[1], bus.s1[1]};
            y_next = {bus.s6[0], bus.s5[0], bus.s4[1], bus.s3[1]};
            z_next = {bus.s2[0], bus.s1[0], bus.s6[1], bus.s5[1]};
            p_next = bus.s7[1];
            q_next = bus.s7[0];
            case (state_reg)
                ST_INIT: begin
                    if (round_reg == INIT_LAST) begin
                        state_next     = ST_GEN;
                        round_next     = 8'd0;
                        init_done_next = 1'b1;
                    end else begin
                        round_next = round_reg + 8'd1;
                    end
                end
                ST_GEN: begin
                    if (round_reg == BYTE_LAST) begin
                        round_next     = 8'd0;
                        byte_cnt_next  = byte_cnt_reg + 16'd1;
                        byte_tick_next = 1'b1;
                    end else begin
                        round_next = round_reg + 8'd1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            x_reg         <= 4'd0;
            y_reg         <= 4'd0;
            z_reg         <= 4'd0;
            p_reg         <= 1'b0;
            q_reg         <= 1'b0;
            round_reg     <= 8'd0;
            byte_cnt_reg  <= 16'd0;
            init_done_reg <= 1'b0;
            byte_tick_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            x_reg         <= x_next;
            y_reg         <= y_next;
            z_reg         <= z_next;
            p_reg         <= p_next;
            q_reg         <= q_next;
            round_reg     <= round_next;
            byte_cnt_reg  <= byte_cnt_next;
            init_done_reg <= init_done_next;
            byte_tick_reg <= byte_tick_next;
        end
    end

    assign bus.x         = x_reg;
    assign bus.y         = y_reg;
    assign bus.z         = z_reg;
    assign bus.p         = p_reg;
    assign bus.q         = q_reg;
    assign bus.gen_mode  = (state_reg == ST_GEN);
    assign bus.busy      = (state_reg != ST_IDLE);
    assign bus.round     = round_reg;
    assign bus.byte_cnt  = byte_cnt_reg;
    assign bus.init_done = init_done_reg;
    assign bus.byte_tick = byte_tick_reg;
endmodule

// File: tb/tb_csa_sbox_capture.sv
// Directed bench for csa_sbox_capture: a default-parameter instance for phase and
// capture behaviour, and a 1-round/1-round instance to reach the byte counter wrap.
module tb_csa_sbox_capture;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    csa_sbox_capture_if bus ();
    csa_sbox_capture_if bus2 ();

    csa_sbox_capture dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    csa_sbox_capture #(.INIT_ROUNDS(1), .ROUNDS_PER_BYTE(1)) dut_wrap (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed output vector: {x,y,z,p,q,gen_mode,busy,round,byte_cnt,init_done,byte_tick}
    function automatic logic [41:0] obs1();
        return {bus.x, bus.y, bus.z, bus.p, bus.q, bus.gen_mode, bus.busy,
                bus.round, bus.byte_cnt, bus.init_done, bus.byte_tick};
    endfunction

    function automatic logic [41:0] obs2();
        return {bus2.x, bus2.y, bus2.z, bus2.p, bus2.q, bus2.gen_mode, bus2.busy,
                bus2.round, bus2.byte_cnt, bus2.init_done, bus2.byte_tick};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_s(input logic [1:0] a, b, c, d, e, f, g);
        bus.s1 = a; bus.s2 = b; bus.s3 = c; bus.s4 = d;
        bus.s5 = e; bus.s6 = f; bus.s7 = g;
    endtask

    task automatic test_reset();
        logic [41:0] exp;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp = '0;
        n_vec++;
        if (obs1() !== exp) begin
            n_err++;
            $display("FAIL reset_values got=%h want=%h", obs1(), exp);
        end
        set_s(2'b11, 2'b10, 2'b01, 2'b11, 2'b10, 2'b01, 2'b11);
        bus.adv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_vec++;
            if (obs1() !== exp) begin
                n_err++;
                $display("FAIL idle_ignores_adv cyc=%0d got=%h want=%h", i, obs1(), exp);
            end
        end
        bus.adv = 1'b0;
        $display("[test_reset] done, %0d miscompares so far", n_err);
    endtask

    task automatic test_capture();
        logic [41:0] exp;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        set_s(2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10);
        bus.adv = 1'b1;
        step();
        bus.adv = 1'b0;
        exp = {4'h5, 4'hE, 4'h5, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 16'd0, 1'b0, 1'b0};
        n_vec++;
        if (obs1() !== exp) begin
            n_err++;
            $display("FAIL capture_map got=%h want=%h", obs1(), exp);
        end
        step();
        n_vec++;
        if (obs1() !== exp) begin
            n_err++;
            $display("FAIL capture_hold got=%h want=%h", obs1(), exp);
        end
        $display("[test_capture] x=%h y=%h z=%h p=%b q=%b round=%0d",
                 bus.x, bus.y, bus.z, bus.p, bus.q, bus.round);
    endtask

    task automatic test_init();
        logic [41:0] exp;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        exp = {12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 16'd0, 1'b0, 1'b0};
        n_vec++;
        if (obs1() !== exp) begin
            n_err++;
            $display("FAIL init_entry got=%h want=%h", obs1(), exp);
        end
        // All sboxes = 01 gives x=y=z=4'hC, p=0, q=1.
        set_s(2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01);
        bus.adv = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            step();
            n_vec++;
            if (bus.gen_mode !== 1'b0 || bus.init_done !== 1'b0 || bus.round !== 8'(i)) begin
                n_err++;
                $display("FAIL init_round i=%0d got gen=%b done=%b round=%0d want gen=0 done=0 round=%0d",
                         i, bus.gen_mode, bus.init_done, bus.round, i);
            end
        end
        step();
        bus.adv = 1'b0;
        exp = {4'hC, 4'hC, 4'hC, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 16'd0, 1'b1, 1'b0};
        n_vec++;
        if (obs1() !== exp) begin
            n_err++;
            $display("FAIL init_to_gen got=%h want=%h", obs1(), exp);
        end
        step();
        exp = {4'hC, 4'hC, 4'hC, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 16'd0, 1'b0, 1'b0};
        n_vec++;
        if (obs1() !== exp) begin
            n_err++;
            $display("FAIL init_done_pulse got=%h want=%h", obs1(), exp);
        end
        $display("[test_init] gen_mode=%b round=%0d byte_cnt=%0d", bus.gen_mode, bus.round, bus.byte_cnt);
    endtask

    task automatic test_gen_gaps();
        logic [41:0] exp;
        logic [1:0]  v;
        logic [3:0]  n;
        logic        tick;
        int          exp_round;
        int          exp_cnt;
        int          ticks;
        exp_round = 0;
        exp_cnt   = 0;
        ticks     = 0;
        for (int i = 0; i < 12; i++) begin
            v = 2'(i + 1);
            set_s(v, v, v, v, v, v, v);
            bus.adv = 1'b1;
            step();
            bus.adv = 1'b0;
            exp_round = (exp_round + 1) % 4;
            tick = (exp_round == 0);
            if (tick) exp_cnt++;
            if (bus.byte_tick === 1'b1) ticks++;
            n = {v[0], v[0], v[1], v[1]};
            exp = {n, n, n, v[1], v[0], 1'b1, 1'b1, 8'(exp_round), 16'(exp_cnt), 1'b0, tick};
            n_vec++;
            if (obs1() !== exp) begin
                n_err++;
                $display("FAIL gen_adv i=%0d got=%h want=%h", i, obs1(), exp);
            end
            if (i % 3 == 1) begin
                set_s(2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11);
                step();
                exp[0] = 1'b0;
                n_vec++;
                if (obs1() !== exp) begin
                    n_err++;
                    $display("FAIL gen_gap_hold i=%0d got=%h want=%h", i, obs1(), exp);
                end
            end
        end
        n_vec++;
        if (ticks != 3 || bus.byte_cnt !== 16'd3) begin
            n_err++;
            $display("FAIL gen_byte_count got ticks=%0d cnt=%0d want ticks=3 cnt=3", ticks, bus.byte_cnt);
        end
        $display("[test_gen_gaps] ticks=%0d byte_cnt=%0d", ticks, bus.byte_cnt);
    endtask

    task automatic test_start_abort();
        logic [41:0] exp;
        set_s(2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b01, 2'b11);
        bus.start = 1'b1;
        bus.adv   = 1'b1;
        step();
        bus.start = 1'b0;
        exp = {12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 16'd0, 1'b0, 1'b0};
        n_vec++;
        if (obs1() !== exp) begin
            n_err++;
            $display("FAIL start_abort got=%h want=%h", obs1(), exp);
        end
        // adv still high: next edge is an INIT capture, x={0,1,1,1}=7, y={1,1,1,0}=E, z={1,0,0,1}=9.
        step();
        bus.adv = 1'b0;
        exp = {4'h7, 4'hE, 4'h9, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1, 16'd0, 1'b0, 1'b0};
        n_vec++;
        if (obs1() !== exp) begin
            n_err++;
            $display("FAIL abort_then_init got=%h want=%h", obs1(), exp);
        end
        $display("[test_start_abort] round=%0d gen_mode=%b", bus.round, bus.gen_mode);
    endtask

    task automatic test_rst_mid_init();
        logic [41:0] exp;
        bus.adv = 1'b1;
        step();
        step();
        n_vec++;
        if (bus.round !== 8'd3 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL pre_rst_round got round=%0d busy=%b want round=3 busy=1", bus.round, bus.busy);
        end
        rst       = 1'b1;
        bus.start = 1'b1;
        step();
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.adv   = 1'b0;
        exp = '0;
        n_vec++;
        if (obs1() !== exp) begin
            n_err++;
            $display("FAIL rst_mid_init got=%h want=%h", obs1(), exp);
        end
        bus.adv = 1'b1;
        step();
        bus.adv = 1'b0;
        n_vec++;
        if (obs1() !== exp) begin
            n_err++;
            $display("FAIL rst_then_idle got=%h want=%h", obs1(), exp);
        end
        $display("[test_rst_mid_init] busy=%b round=%0d", bus.busy, bus.round);
    endtask

    task automatic test_byte_wrap();
        logic [41:0] exp;
        bus2.start = 1'b1;
        step();
        bus2.start = 1'b0;
        bus2.adv   = 1'b1;
        step();
        exp = {12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 16'd0, 1'b1, 1'b0};
        n_vec++;
        if (obs2() !== exp) begin
            n_err++;
            $display("FAIL wrap_init_done got=%h want=%h", obs2(), exp);
        end
        for (int i = 0; i < 65535; i++) step();
        exp = {12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 16'd65535, 1'b0, 1'b1};
        n_vec++;
        if (obs2() !== exp) begin
            n_err++;
            $display("FAIL wrap_preload got=%h want=%h", obs2(), exp);
        end
        step();
        bus2.adv = 1'b0;
        exp = {12'h000, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 16'd0, 1'b0, 1'b1};
        n_vec++;
        if (obs2() !== exp) begin
            n_err++;
            $display("FAIL wrap_to_zero got=%h want=%h", obs2(), exp);
        end
        step();
        exp[0] = 1'b0;
        n_vec++;
        if (obs2() !== exp) begin
            n_err++;
            $display("FAIL wrap_tick_pulse got=%h want=%h", obs2(), exp);
        end
        $display("[test_byte_wrap] byte_cnt=%0d byte_tick=%b", bus2.byte_cnt, bus2.byte_tick);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.adv    = 1'b0;
        set_s(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        bus2.start = 1'b0;
        bus2.adv   = 1'b0;
        bus2.s1 = 2'b00; bus2.s2 = 2'b00; bus2.s3 = 2'b00; bus2.s4 = 2'b00;
        bus2.s5 = 2'b00; bus2.s6 = 2'b00; bus2.s7 = 2'b00;

        test_reset();
        test_capture();
        test_init();
        test_gen_gaps();
        test_start_abort();
        test_rst_mid_init();
        test_byte_wrap();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/csa_sbox_capture.md
# csa_sbox_capture

Round-state capture stage for the CSA stream cipher, directly downstream of the 7-sbox combinational layer. Each round it registers the seven 2-bit sbox outputs into the X, Y, Z nibbles and the p, q carry bits that the next round's state update consumes. It also sequences the cipher phases: IDLE, then a fixed number of initialisation rounds, then keystream generation. During generation it counts rounds per output byte and counts bytes.

## Interface
- INIT_ROUNDS, default 32: number of captured rounds in the initialisation phase; legal range 1..255.
- ROUNDS_PER_BYTE, default 4: generation rounds per keystream byte (2 bits per round); legal range 1..255.
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a new key/IV session; restarts from any state.
- adv  in  1  advance one round: capture s1..s7 this edge.
- s1..s7  in  2 each  sbox outputs for the current round.
- x, y, z  out  4 each  registered state nibbles.
- p, q  out  1 each  registered carry bits.
- gen_mode  out  1  1 while in the GEN state.
- busy  out  1  1 while in INIT or GEN.
- round  out  8  round index within the current phase.
- byte_cnt  out  16  number of completed keystream bytes.
- init_done  out  1  one-cycle pulse on entry to GEN.
- byte_tick  out  1  one-cycle pulse per completed byte.

## Operation
- States: IDLE, INIT, GEN.
- Capture mapping, applied on an accepted adv:
  - x = {s4[0], s3[0], s2[1], s1[1]}
  - y = {s6[0], s5[0], s4[1], s3[1]}
  - z = {s2[0], s1[0], s6[1], s5[1]}
  - p = s7[1], q = s7[0]
- IDLE:
  - adv is ignored; x, y, z, p, q hold.
  - start → INIT. On the same edge: x, y, z, p, q, round and byte_cnt are cleared to 0.
- INIT:
  - Each adv captures the sbox outputs and increments round.
  - The adv that captures round INIT_ROUNDS-1 moves to GEN. On that edge round is set to 0 and init_done is registered high.
- GEN:
  - Each adv captures the sbox outputs and advances round modulo ROUNDS_PER_BYTE.
  - On the adv that wraps round from ROUNDS_PER_BYTE-1 to 0: byte_cnt increments and byte_tick is registered high.
  - byte_cnt wraps from 65535 to 0 without stopping.
  - GEN runs until start or rst.
- Priority: rst > start > adv.
  - start together with adv: adv is dropped. The cycle after shows cleared state with round = 0 in INIT.
  - start during INIT or GEN aborts the session and re-enters INIT with cleared state.
- No adv in a cycle: all registers hold; init_done and byte_tick are 0.

## Timing
- All outputs are registered and change only on a rising clk edge.
- Capture latency: an adv sampled at edge N makes the new x, y, z, p, q visible after edge N. There is one cycle of latency; no combinational path runs from any input to any output.
- adv may be asserted every cycle, giving full throughput of one round per clock.
- gen_mode and init_done rise in the same cycle. init_done lasts exactly one cycle.
- byte_tick is visible in the same cycle as the updated byte_cnt and round = 0. It lasts exactly one cycle.
- Reset values: x = 0, y = 0, z = 0, p = 0, q = 0, round = 0, byte_cnt = 0, gen_mode = 0, busy = 0, init_done = 0, byte_tick = 0, state IDLE.
- rst asserted mid-INIT or mid-GEN returns to IDLE with the reset values on the next cycle, regardless of start or adv.
- busy = 1 from the cycle after start until the cycle after rst.

## Test plan
- Reset, then adv held high for 5 cycles with start = 0: all outputs remain 0 and the state stays IDLE.
- Stimulus: start, then one adv with s1=11, s2=00, s3=01, s4=10, s5=11, s6=01, s7=10. Required next cycle: x=4'h5, y=4'hE, z=4'h5, p=1, q=0, round=1.
- Stimulus: start, then 32 back-to-back advs (defaults). Required: init_done and gen_mode rise exactly one cycle after the 32nd adv, round=0, byte_cnt=0, init_done low the following cycle.
- Stimulus: in GEN, 12 advs with idle gaps inserted. Required: round sequence 1,2,3,0 repeating; byte_tick exactly 3 times; byte_cnt=3; all registers hold during the gaps.
- Stimulus: start and adv asserted together mid-GEN with nonzero s inputs. Required next cycle: state INIT, x=y=z=0, p=q=0, round=0, byte_cnt=0, gen_mode=0.
- Stimulus: byte_cnt preloaded to 65535 by running 65535 bytes, then one more byte. Required: byte_cnt=0 and byte_tick=1. Separately, rst mid-INIT → reset values the next cycle.
